// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one flash read port between the audio sample
// fetcher (port 0) and the indicator sample reader (port 1). One word read
// is outstanding at a time; contention is resolved round-robin, and a read
// whose data never returns is aborted after TIMEOUT_CYCLES in WAIT_VALID.
module flash_read_arbiter #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk50M,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] rdata,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic              busy,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [DATA_W-1:0] flash_mem_readdata
);

    // Counter only has to reach TIMEOUT_CYCLES-1; it never wraps because the
    // FSM leaves WAIT_VALID on that value.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_VALID,
        RESPOND
    } state_t;

    state_t           state;
    logic             gnt;         // requester owning the current read
    logic             last_grant;  // requester served most recently
    logic [CNT_W-1:0] tmo_cnt;
    logic             pick;        // requester that would win in IDLE now

    // Whole-word reads only.
    assign flash_mem_byteenable = 4'hF;

    // Round-robin choice: a lone requester wins outright; on contention the
    // one not served last time wins.
    assign pick = (req0 && req1) ? ~last_grant : req1;

    // Arbitration and flash read handshake FSM with registered outputs.
    // NOTE: every register here uses non-blocking assignment so all state
    // updates on one edge see the same pre-edge values, independent of order.
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            gnt               <= 1'b0;
            last_grant        <= 1'b1;
            tmo_cnt           <= '0;
            rdata             <= '0;
            done0             <= 1'b0;
            done1             <= 1'b0;
            err               <= 1'b0;
            busy              <= 1'b0;
            flash_mem_read    <= 1'b0;
            flash_mem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt               <= pick;
                        flash_mem_address <= pick ? addr1 : addr0;
                        flash_mem_read    <= 1'b1;
                        busy              <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Stall indefinitely here; the timeout covers only the
                    // data phase.
                    if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        tmo_cnt        <= '0;
                        state          <= WAIT_VALID;
                    end
                end
                WAIT_VALID: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Returning data beats a simultaneous timeout.
                    if (flash_mem_readdatavalid) begin
                        rdata <= flash_mem_readdata;
                        err   <= 1'b0;
                        done0 <= ~gnt;
                        done1 <= gnt;
                        state <= RESPOND;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        done0 <= ~gnt;
                        done1 <= gnt;
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    done0      <= 1'b0;
                    done1      <= 1'b0;
                    err        <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= gnt;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: a flash slave model issues expectations into
// a scoreboard queue at read acceptance; a separate monitor pops and compares
// on every done pulse.
module tb_flash_read_arbiter;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              clk50M = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [DATA_W-1:0] rdata;
    logic              done0, done1, err, busy;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest = 1'b0;
    logic              flash_mem_readdatavalid = 1'b0;
    logic [DATA_W-1:0] flash_mem_readdata = '0;

    flash_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk50M(clk50M), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .rdata(rdata), .done0(done0), .done1(done1), .err(err), .busy(busy),
        .flash_mem_read(flash_mem_read),
        .flash_mem_address(flash_mem_address),
        .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .flash_mem_readdata(flash_mem_readdata)
    );

    always #10 clk50M = ~clk50M;

    int cyc = 0;
    always @(posedge clk50M) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // Flash slave behaviour knobs; negative means randomise per read.
    int          cfg_stall = 0;
    int          cfg_k = 1;       // data delay after acceptance, 0 = never
    bit          cfg_data_en = 0;
    logic [31:0] cfg_data = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk50M);
        #2;
    endtask

    task automatic set_req(input int p, input logic v, input logic [ADDR_W-1:0] a);
        if (p == 0) begin
            req0 = v; addr0 = a;
        end else begin
            req1 = v; addr1 = a;
        end
    endtask

    task automatic wait_done(input int p, input string name);
        bit seen;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            tick();
            seen = (p == 1) ? done1 : done0;
        end
        check(name, seen, 1);
    endtask

    // Level requester: keeps req high until its done, then either chains a
    // new request straight away or idles for a while.
    task automatic requester(input int p, input int n);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom);
        set_req(p, 1, a);
        for (int i = 0; i < n; i++) begin
            wait_done(p, "rand_done");
            tick();
            if (i == n - 1) begin
                set_req(p, 0, a);
            end else if ($urandom_range(0, 1) == 1) begin
                a = ADDR_W'($urandom);
                set_req(p, 1, a);
            end else begin
                set_req(p, 0, a);
                repeat ($urandom_range(1, 5)) tick();
                a = ADDR_W'($urandom);
                set_req(p, 1, a);
            end
        end
    endtask

    // Contention run: returns after n completions, recording who got each.
    task automatic contend(input int n, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        int who;
        set_req(0, 1, a0);
        set_req(1, 1, a1);
        for (int g = 0; g < n; g++) begin
            who = -1;
            for (int t = 0; t < 50 && who < 0; t++) begin
                tick();
                if (done0 || done1) who = done1 ? 1 : 0;
            end
            check("contend_order", who, g % 2);
        end
        tick();
        set_req(0, 0, a0);
        set_req(1, 0, a1);
    endtask

    // Flash slave model and grant/busy reference.
    initial begin : flash_model
        bit          prev_read, acc_prev, in_flight, pending;
        logic [1:0]  prev_req;
        logic [ADDR_W-1:0] prev_a0, prev_a1, cur_addr, exp_addr;
        int          cur_port, last, stall_left, rdv_at, done_at, k, r;
        logic [31:0] pdata;
        exp_t        e;
        prev_read = 0; acc_prev = 0; in_flight = 0; pending = 0;
        prev_req = '0; prev_a0 = '0; prev_a1 = '0; cur_addr = '0;
        cur_port = 0; last = 1; stall_left = 0; rdv_at = -1; done_at = -1;
        pdata = '0;
        forever begin
            @(negedge clk50M);
            flash_mem_readdatavalid = 1'b0;
            flash_mem_readdata = $urandom;
            if (!reset_n) begin
                in_flight = 0; acc_prev = 0; last = 1; done_at = -1;
                exp_q.delete();
            end else begin
                if (flash_mem_read && !prev_read) begin
                    check("grant_had_req", prev_req != 2'b00, 1);
                    if (prev_req == 2'b11) cur_port = 1 - last;
                    else cur_port = prev_req[1] ? 1 : 0;
                    exp_addr = (cur_port == 1) ? prev_a1 : prev_a0;
                    check("grant_addr", flash_mem_address, exp_addr);
                    last = cur_port;
                    cur_addr = flash_mem_address;
                    in_flight = 1;
                    done_at = -1;
                    if (cfg_stall >= 0) stall_left = cfg_stall;
                    else stall_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                end
                if (flash_mem_read) begin
                    check("read_drop", acc_prev, 0);
                    check("addr_stable", flash_mem_address, cur_addr);
                    if (stall_left > 0) begin
                        flash_mem_waitrequest = 1'b1;
                        stall_left--;
                        acc_prev = 0;
                    end else begin
                        flash_mem_waitrequest = 1'b0;
                        acc_prev = 1;
                        if (cfg_k >= 0) k = cfg_k;
                        else begin
                            r = $urandom_range(0, 9);
                            if (r < 6) k = $urandom_range(1, 3);
                            else if (r < 8) k = $urandom_range(4, TMO);
                            else if (r < 9) k = $urandom_range(TMO + 1, TMO + 2);
                            else k = 0;
                        end
                        pdata = cfg_data_en ? cfg_data : $urandom;
                        e.port = cur_port;
                        if (k >= 1 && k <= TMO) begin
                            e.data = pdata; e.err = 1'b0; e.cyc = cyc + k + 1;
                        end else begin
                            e.data = '0; e.err = 1'b1; e.cyc = cyc + TMO + 1;
                        end
                        exp_q.push_back(e);
                        done_at = e.cyc;
                        pending = (k >= 1);
                        rdv_at = cyc + k;
                    end
                end else begin
                    flash_mem_waitrequest = 1'($urandom_range(0, 1));
                    acc_prev = 0;
                end
                check("busy", busy, in_flight);
                if (in_flight && cyc == done_at) in_flight = 0;
            end
            // Data may come back after a reset; the DUT has to ignore it.
            if (pending && cyc == rdv_at) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata = pdata;
                pending = 0;
            end
            prev_read = flash_mem_read;
            prev_req = {req1, req0};
            prev_a0 = addr0;
            prev_a1 = addr1;
        end
    end

    // Monitor: compare every completion against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk50M);
            if (reset_n) begin
                if (done0 || done1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {done1, done0}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_port", {done1, done0}, (e.port == 1) ? 2'b10 : 2'b01);
                        check("rdata", rdata, e.data);
                        check("err", err, e.err);
                        check("done_cycle", cyc, e.cyc);
                    end
                end else if (err) begin
                    check("err_without_done", err, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  t0;
        bit  seen;
        // Reset state.
        repeat (3) tick();
        check("rst_rdata", rdata, 0);
        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_err", err, 0);
        check("rst_read", flash_mem_read, 0);
        check("rst_addr", flash_mem_address, 0);
        check("rst_busy", busy, 0);
        check("byteenable", flash_mem_byteenable, 4'hF);
        reset_n = 1'b1;
        tick();

        // Contention straight after reset: requester 0 first, then alternate.
        cfg_stall = 0; cfg_k = 1; cfg_data_en = 0;
        contend(4, 23'h7FFFF, 23'h00000);
        repeat (2) tick();

        // Single uncontended read with known data and minimum latency.
        cfg_data_en = 1; cfg_data = 32'hA1B2C3D4;
        set_req(0, 1, 23'h00010);
        t0 = cyc;
        wait_done(0, "single_done");
        check("single_latency", cyc - t0, 3);
        check("single_rdata", rdata, 32'hA1B2C3D4);
        check("single_done1", done1, 0);
        tick();
        set_req(0, 0, 23'h00010);
        cfg_data_en = 0;
        repeat (2) tick();

        // Waitrequest stall of 5 cycles.
        cfg_stall = 5;
        set_req(0, 1, 23'h01234);
        t0 = cyc;
        wait_done(0, "stall_done");
        check("stall_latency", cyc - t0, 8);
        tick();
        set_req(0, 0, 23'h01234);
        cfg_stall = 0;
        repeat (2) tick();

        // Timeout: data never returns.
        cfg_k = 0;
        set_req(1, 1, 23'h05555);
        t0 = cyc;
        wait_done(1, "tmo_done");
        check("tmo_latency", cyc - t0, TMO + 2);
        check("tmo_err", err, 1);
        check("tmo_rdata", rdata, 0);
        tick();
        set_req(1, 0, 23'h05555);
        check("tmo_busy_falls", busy, 0);
        cfg_k = 1;
        repeat (2) tick();

        // Request withdrawn right after its grant.
        set_req(1, 1, 23'h00ABC);
        tick();
        check("wd_granted", flash_mem_read, 1);
        set_req(1, 0, 23'h00ABC);
        wait_done(1, "wd_done");
        repeat (4) tick();
        check("wd_no_reissue", {busy, flash_mem_read}, 2'b00);

        // Randomised traffic from both requesters.
        cfg_stall = -1; cfg_k = -1;
        fork
            requester(0, 25);
            requester(1, 25);
        join
        repeat (TMO + 6) tick();

        // Reset during WAIT_VALID; late data must be ignored.
        cfg_stall = 0; cfg_k = 6;
        set_req(0, 1, 23'h03C3C);
        repeat (3) tick();
        check("mid_in_wait", {busy, flash_mem_read}, 2'b10);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_outputs",
              {rdata, done0, done1, err, busy, flash_mem_read, flash_mem_address}, 0);
        set_req(0, 0, 23'h03C3C);
        repeat (2) tick();
        reset_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            seen = seen | done0 | done1;
        end
        check("mid_no_done", seen, 0);
        check("mid_idle", {busy, flash_mem_read}, 2'b00);

        // last_grant is restored by reset: requester 0 wins again.
        cfg_k = 1;
        contend(2, 23'h00111, 23'h00222);
        repeat (3) tick();

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
